// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the parametrised register file.
package reg_file_pkg;

  localparam int REG_FILE_DATA_W_DEF   = 8;
  localparam int REG_FILE_NUM_REGS_DEF = 4;

  // NUM_REGS need not be a power of two, so the top address codes can be unused.
  function automatic logic addr_in_range(input int unsigned addr, input int unsigned num_regs);
    return addr < num_regs;
  endfunction

endpackage

// File: rtl/reg_file_rdport.sv
// One asynchronous read port: register mux, out-of-range zeroing, busy lookup.
// With REG_FILE_BYPASS_EN defined, a same-cycle write to the addressed register is forwarded.
module reg_file_rdport
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = REG_FILE_DATA_W_DEF,
  parameter int NUM_REGS = REG_FILE_NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic [NUM_REGS-1:0][DATA_W-1:0] regs_i,
  input  logic [NUM_REGS-1:0]             pend_i,
  input  logic [ADDR_W-1:0]               rd_addr_i,
`ifdef REG_FILE_BYPASS_EN
  input  logic                            rst_n_i,
  input  logic                            wr_en_i,
  input  logic [ADDR_W-1:0]               wr_addr_i,
  input  logic [DATA_W-1:0]               wr_data_i,
`endif
  output logic [DATA_W-1:0]               rd_data_o,
  output logic                            busy_o
);

  always_comb begin
    rd_data_o = '0;
    busy_o    = 1'b0;
    if (addr_in_range(32'(rd_addr_i), NUM_REGS)) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rd_addr_i == ADDR_W'(i)) begin
          rd_data_o = regs_i[i];
          busy_o    = pend_i[i];
        end
      end
`ifdef REG_FILE_BYPASS_EN
      // Gated by reset so a held reset always reads as zero.
      if (rst_n_i && wr_en_i && (wr_addr_i == rd_addr_i)) begin
        rd_data_o = wr_data_i;
        busy_o    = 1'b0;
      end
`endif
    end
  end

endmodule

// File: rtl/reg_file.sv
// Register file: NUM_REGS x DATA_W, one write port, two async read ports, pending scoreboard.
// Optional same-cycle write-to-read forwarding via REG_FILE_BYPASS_EN.
module reg_file
  import reg_file_pkg::*;
#(
  parameter  int DATA_W   = REG_FILE_DATA_W_DEF,
  parameter  int NUM_REGS = REG_FILE_NUM_REGS_DEF,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              busy_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              busy_b,
  input  logic              pend_set,
  input  logic [ADDR_W-1:0] pend_addr
);

  localparam int NUM_PORTS = 2;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]             pend_q, pend_d;
  logic                            wr_hit, pend_hit;

  always_comb begin
    regs_d   = regs_q;
    pend_d   = pend_q;
    wr_hit   = wr_en    && addr_in_range(32'(wr_addr), NUM_REGS);
    pend_hit = pend_set && addr_in_range(32'(pend_addr), NUM_REGS);
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_hit && (wr_addr == ADDR_W'(i))) begin
        regs_d[i] = wr_data;
        pend_d[i] = 1'b0;
      end
      // A new pend_set outranks the retiring write on the same register.
      if (pend_hit && (pend_addr == ADDR_W'(i))) pend_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  logic [NUM_PORTS-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rd_data;
  logic [NUM_PORTS-1:0]             busy;

  assign rd_addr = {rd_addr_b, rd_addr_a};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rdport
    reg_file_rdport #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
    ) u_rdport (
      .regs_i    (regs_q),
      .pend_i    (pend_q),
      .rd_addr_i (rd_addr[p]),
`ifdef REG_FILE_BYPASS_EN
      .rst_n_i   (rst_n),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
`endif
      .rd_data_o (rd_data[p]),
      .busy_o    (busy[p])
    );
  end

  assign rd_data_a = rd_data[0];
  assign busy_a    = busy[0];
  assign rd_data_b = rd_data[1];
  assign busy_b    = busy[1];

endmodule

// File: doc/reg_file.md
# reg_file

Parametrised register file, successor to the fixed 4×8 `regbank`. It holds NUM_REGS registers of DATA_W bits, with one synchronous write port and two asynchronous read ports. An optional write-to-read bypass lets the datapath read a register in the same cycle it is written. A per-register pending scoreboard tracks registers whose write-back is still in flight. It sits between the decoder (read/pending addresses) and the ALU/memory write-back stage.

## Interface
- DATA_W, 8, register width in bits (≥1)
- NUM_REGS, 4, number of registers (≥2; need not be a power of two)
- ADDR_W, $clog2(NUM_REGS), derived localparam, not overridable
- clk  in  1  rising-edge clock; one clock only
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write strobe, sampled at clk rising edge
- wr_addr  in  ADDR_W  write target
- wr_data  in  DATA_W  write value
- rd_addr_a  in  ADDR_W  read port A address
- rd_data_a  out  DATA_W  read port A data (combinational)
- busy_a  out  1  register addressed by port A is pending
- rd_addr_b  in  ADDR_W  read port B address
- rd_data_b  out  DATA_W  read port B data (combinational)
- busy_b  out  1  register addressed by port B is pending
- pend_set  in  1  mark register pend_addr as pending at next edge
- pend_addr  in  ADDR_W  register to mark pending

## Operation
- Reset (rst_n=0): all registers = 0 and all pending bits = 0, applied immediately without waiting for clk. While reset is held, rd_data_a/b = 0 and busy_a/b = 0, regardless of bypass.
- Write: at a rising edge with wr_en=1 and wr_addr<NUM_REGS, reg[wr_addr] ← wr_data and pend[wr_addr] ← 0.
- Out-of-range write (wr_addr≥NUM_REGS): ignored.
- Pending set: at a rising edge with pend_set=1 and pend_addr<NUM_REGS, pend[pend_addr] ← 1.
- Set/clear collision: if pend_set and wr_en target the same register in the same cycle, data is written and pend ends at 1. Set wins, because the newer op issued while the older one retires.
- Pending without a write: a pending bit set with no later write stays set until reset.
- Read: rd_data_x = reg[rd_addr_x] and busy_x = pend[rd_addr_x].
- Out-of-range read: rd_data_x = 0 and busy_x = 0.
- Ports A and B are fully independent. Both may address the same register.
- Arithmetic: none. Data is stored verbatim with no width conversion.

## Timing
- Write latency: 1 edge. Without bypass, the new value is visible on the read ports right after the writing edge.
- Pending: busy rises right after the pend_set edge and falls right after the clearing write edge.
- Read path: purely combinational from address/state to data. There is no read latency.
- Reset: asynchronous assertion. Deassertion is assumed synchronous to clk by the reset generator; no internal synchroniser.

## Configuration
- Macro: REG_FILE_BYPASS_EN.
- Defined: when wr_en=1 and wr_addr==rd_addr_x (in range, rst_n=1), the same cycle gives rd_data_x = wr_data and busy_x = 0. Bypass applies per port independently.
- Undefined: no forwarding. Reads return stored contents and busy reflects the stored pend bit only. A same-cycle write is visible on the next cycle.

## Structure
- Package reg_file_pkg:
  - default constants REG_FILE_DATA_W_DEF=8 and REG_FILE_NUM_REGS_DEF=4
  - function for the in-range address check
- Sub-module reg_file_rdport, instantiated twice (A, B):
  - read mux
  - out-of-range zeroing
  - bypass compare under REG_FILE_BYPASS_EN
  - busy generation
- Storage array, pending vector and write/pending logic live in reg_file.

## Test plan
- Reset and write/read (defaults): assert rst_n=0, then release. Write 0x38→r0, 0x2B→r1, 0x23→r2, 0x03→r3. Expect all reads 0 before the writes, then each value read back on both ports one edge after its write.
- Write-enable low: wr_en=0 with wr_data=0x3F on r0 → r0 stays 0x38.
- Bypass: write 0xEB to r1 while rd_addr_a=1.
  - With REG_FILE_BYPASS_EN: rd_data_a=0xEB in the same cycle.
  - Without it: 0x2B that cycle, then 0xEB after the edge.
- Scoreboard: pend_set on r2, rd_addr_b=2 → busy_b=1 after the edge. Write 0xFB to r2 → busy_b=0 and rd_data_b=0xFB after the edge. Assert pend_set and wr_en on r3 together → r3=data and busy=1.
- Reset mid-operation: with r0..r3 nonzero and r2 pending, pull rst_n low between edges → all rd_data and busy are 0 immediately, before the next clk edge.
- Parametrisation: DATA_W=16, NUM_REGS=5.
  - Write 0xBEEF→r4 and read it back.
  - Write to address 6 → ignored.
  - Read address 7 → returns 0 with busy=0.
